// File: rtl/si_arb_pkg.sv
// Shared types and constants for the SI bus arbiter.
package si_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } si_arb_state_t;

    localparam int SI_ADDR_W = 32;
    localparam int SI_DATA_W = 32;

    localparam logic [SI_ADDR_W-1:0] SI_BASE_ADC = 32'hA000_0000;

endpackage

// File: rtl/si_rr_picker.sv
// Round-robin search: first set bit of mask at or above ptr, wrapping modulo N.
module si_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Walk N positions starting at ptr; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/si_bus_arbiter.sv
// Round-robin owner of the shared SI bus: one transaction at a time, locked
// bursts keep the grant, and a watchdog aborts transactions that never see fin.
module si_bus_arbiter
    import si_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [N-1:0]           req_valid,
    input  logic [N-1:0]           req_lock,
    input  logic [N-1:0]           req_we,
    input  logic [N*SI_ADDR_W-1:0] req_address,
    input  logic [N*SI_DATA_W-1:0] req_data,
    output logic [N-1:0]           req_done,
    output logic                   req_err,
    output logic [N-1:0]           grant,
    output logic                   exec,
    output logic                   we,
    output logic [SI_ADDR_W-1:0]   si_address,
    output logic [SI_DATA_W-1:0]   si_data,
    input  logic                   fin
);

    localparam int IW = $clog2(N);
    // WAIT lasts TIMEOUT+1 cycles (count 0..TIMEOUT), so an abort reports
    // req_done exactly TIMEOUT+2 cycles after the exec strobe.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT);

    si_arb_state_t state, state_n;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic          locked_q;
    logic [7:0]    cnt;
    logic          timed_out;

    logic [N-1:0]  owner_mask;
    logic [N-1:0]  cand_mask;
    logic          found;
    logic [IW-1:0] pick;
    logic [N-1:0]  pick_oh;

    // Candidate set: everyone, or only the burst owner while locked.
    always_comb begin
        owner_mask        = '0;
        owner_mask[owner] = 1'b1;
        pick_oh           = '0;
        pick_oh[pick]     = 1'b1;
        cand_mask         = locked_q ? (req_valid & owner_mask) : req_valid;
    end

    si_rr_picker #(.N(N)) u_picker (
        .mask  (cand_mask),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!nreset) state <= IDLE;
        else         state <= state_n;
    end

    // Next state; fin wins over the watchdog when both land in the same cycle.
    always_comb begin
        state_n   = state;
        timed_out = 1'b0;
        unique case (state)
            IDLE:  if (found) state_n = ISSUE;
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (fin) begin
                    state_n = DONE;
                end else if (cnt == TO_LAST) begin
                    state_n   = DONE;
                    timed_out = 1'b1;
                end
            end
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Grant/bus-field latches, lock tracking, watchdog and completion strobes.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            rr_ptr     <= '0;
            owner      <= '0;
            locked_q   <= 1'b0;
            cnt        <= '0;
            grant      <= '0;
            exec       <= 1'b0;
            we         <= 1'b0;
            si_address <= '0;
            si_data    <= '0;
            req_done   <= '0;
            req_err    <= 1'b0;
        end else begin
            exec     <= 1'b0;
            req_done <= '0;
            req_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant      <= pick_oh;
                        we         <= req_we[pick];
                        si_address <= req_address[pick*SI_ADDR_W +: SI_ADDR_W];
                        si_data    <= req_data[pick*SI_DATA_W +: SI_DATA_W];
                        locked_q   <= req_lock[pick];
                        owner      <= pick;
                        rr_ptr     <= (pick == IW'(N-1)) ? '0 : pick + 1'b1;
                        exec       <= 1'b1;
                    end else if (locked_q && !req_valid[owner] && !req_lock[owner]) begin
                        // Owner walked away from its burst: release the lock.
                        locked_q <= 1'b0;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (state_n == DONE) begin
                        req_done <= grant;
                        req_err  <= timed_out;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: grant <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_si_bus_arbiter.sv
// Randomised bench for si_bus_arbiter: a scoreboard fed by the bus target and
// a monitor running a round-robin/lock reference model on sampled requests.
module tb_si_bus_arbiter;

    localparam int N = 4;
    localparam int T = 16;

    logic             clk = 1'b0;
    logic             nreset;
    logic [N-1:0]     req_valid, req_lock, req_we;
    logic [N*32-1:0]  req_address, req_data;
    logic [N-1:0]     req_done, grant;
    logic             req_err, exec, we, fin;
    logic [31:0]      si_address, si_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    si_bus_arbiter #(.N(N), .TIMEOUT(T)) dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
        .req_address(req_address), .req_data(req_data),
        .req_done(req_done), .req_err(req_err), .grant(grant),
        .exec(exec), .we(we), .si_address(si_address), .si_data(si_data),
        .fin(fin)
    );

    // Inputs as the DUT saw them at the most recent rising edge.
    logic [N-1:0]    s_valid, s_lock, s_we;
    logic [N*32-1:0] s_addr, s_data;
    logic            s_rst;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        s_valid <= req_valid;
        s_lock  <= req_lock;
        s_we    <= req_we;
        s_addr  <= req_address;
        s_data  <= req_data;
        s_rst   <= nreset;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int g);
        return N'(1) << g;
    endfunction

    function automatic logic bitof(input logic [N-1:0] v, input int i);
        return v[i[$clog2(N)-1:0]];
    endfunction

    // ---------------- bus target: drives fin, pushes expected completions
    typedef struct { logic err; int done_cyc; } exp_t;
    exp_t sb[$];
    int   fin_mode = 1;   // 0 random, 1 immediate, 2 two cycles, 3 never
    int   fin_a = -1, fin_b = -1;
    int   t_mode, t_d;
    exp_t t_e;

    initial begin
        fin = 1'b0;
        forever begin
            @(negedge clk);
            if (!s_rst) begin
                sb.delete();
                fin_a = -1;
                fin_b = -1;
            end else if (exec) begin
                fin_a = -1;
                fin_b = -1;
                case (fin_mode)
                    1: t_mode = 0;
                    2: t_mode = 1;
                    3: t_mode = 4;
                    default: t_mode = $urandom_range(0, 7);
                endcase
                case (t_mode)
                    0: t_d = 1;
                    1: t_d = 2;
                    2: t_d = $urandom_range(1, T + 1);
                    3: t_d = T + 1;                           // last WAIT cycle
                    4: t_d = -1;                              // never
                    5: begin t_d = -1; fin_b = cyc; end       // stray in ISSUE only
                    6: begin t_d = 2;  fin_b = cyc; end       // stray in ISSUE, then real
                    default: begin t_d = -1; fin_b = cyc + T + 2; end  // late fin lands in DONE
                endcase
                if (t_d > 0) fin_a = cyc + t_d;
                t_e.err      = (t_d < 0);
                t_e.done_cyc = (t_d < 0) ? cyc + T + 2 : cyc + t_d + 1;
                sb.push_back(t_e);
            end
            fin = (cyc == fin_a) || (cyc == fin_b);
        end
    end

    // ---------------- monitor with reference model
    int           g_q[$];
    int           ex_cyc[$];
    logic [N-1:0] ex_g[$];
    int           in_flight = 0;
    int           last_done = -100;
    int           rr = 0, owner = 0, m_g;
    logic         locked = 1'b0;
    logic         exp_exec;
    logic [N-1:0] cand;
    exp_t         m_e;

    initial begin
        forever begin
            @(negedge clk);
            if (!s_rst) begin
                g_q.delete();
                in_flight = 0;
                last_done = -100;
                rr = 0;
                owner = 0;
                locked = 1'b0;
            end else begin
                // completion side
                if (sb.size() > 0 && g_q.size() > 0 && (req_done != '0 || cyc >= sb[0].done_cyc)) begin
                    m_e = sb.pop_front();
                    m_g = g_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(m_e.done_cyc));
                    chk("done_vec", req_done, oh(m_g));
                    chk("done_err", req_err, m_e.err);
                    chk("done_grant", grant, oh(m_g));
                    in_flight = 0;
                    last_done = cyc;
                end else if (req_done != '0) begin
                    chk("stray_done", req_done, '0);
                end
                if (cyc == last_done + 1) chk("grant_idle", grant, '0);

                // issue side: was the DUT idle at the edge that just passed?
                exp_exec = 1'b0;
                if (in_flight == 0 && cyc - 1 > last_done) begin
                    cand = locked ? (s_valid & oh(owner)) : s_valid;
                    if (cand != '0) begin
                        exp_exec = 1'b1;
                        m_g = -1;
                        for (int k = 0; k < N; k++)
                            if (m_g < 0 && bitof(cand, (rr + k) % N)) m_g = (rr + k) % N;
                    end else if (locked && !bitof(s_valid, owner) && !bitof(s_lock, owner)) begin
                        locked = 1'b0;
                    end
                end
                if (exp_exec) begin
                    chk("exec", exec, 1'b1);
                    chk("issue_grant", grant, oh(m_g));
                    chk("issue_we", we, bitof(s_we, m_g));
                    chk("issue_addr", si_address, s_addr[m_g*32 +: 32]);
                    chk("issue_data", si_data, s_data[m_g*32 +: 32]);
                    g_q.push_back(m_g);
                    in_flight = 1;
                    rr = (m_g + 1) % N;
                    locked = bitof(s_lock, m_g);
                    owner = m_g;
                end else if (exec) begin
                    chk("unexpected_exec", exec, 1'b0);
                end
                if (exec) begin
                    ex_cyc.push_back(cyc);
                    ex_g.push_back(grant);
                end
            end
        end
    end

    // ---------------- requester stimulus
    int           gap[N], left[N], starts[N];
    logic [N-1:0] act = '0, en = '0;
    int           gap_max = 0, burst_max = 1;

    task automatic new_beat(input int i);
        req_valid[i] = 1'b1;
        req_lock[i]  = (left[i] > 1);
        req_we[i]    = 1'($urandom_range(0, 1));
        req_address[i*32 +: 32] = si_arb_pkg::SI_BASE_ADC + ($urandom & 32'h0000_FFFC);
        req_data[i*32 +: 32]    = $urandom;
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (act[i] && req_done[i]) begin
                left[i]--;
                if (left[i] > 0) new_beat(i);
                else begin
                    act[i] = 1'b0;
                    req_valid[i] = 1'b0;
                    req_lock[i] = 1'b0;
                    gap[i] = $urandom_range(0, gap_max);
                end
            end else if (!act[i] && en[i] && starts[i] > 0) begin
                if (gap[i] > 0) gap[i]--;
                else begin
                    act[i] = 1'b1;
                    starts[i]--;
                    left[i] = $urandom_range(1, burst_max);
                    new_beat(i);
                end
            end
        end
    endtask

    task automatic drain(input int lim);
        int n = 0;
        int pend;
        do begin
            pend = 0;
            for (int i = 0; i < N; i++) pend += (en[i] ? starts[i] : 0);
            if (act != '0 || pend != 0 || in_flight != 0) begin
                step();
                n++;
            end
        end while ((act != '0 || pend != 0 || in_flight != 0) && n < lim);
        chk("drain_bound", 64'(n < lim), 64'd1);
        repeat (3) step();
    endtask

    task automatic wait_exec(input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (!exec && n < 40);
        chk(nm, exec, 1'b1);
    endtask

    task automatic set_phase(input logic [N-1:0] e, input int st, input int gm, input int bm, input int fm);
        en = e;
        gap_max = gm;
        burst_max = bm;
        fin_mode = fm;
        for (int i = 0; i < N; i++) begin
            starts[i] = st;
            gap[i] = 0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_exec"}, exec, 1'b0);
        chk({tag, "_grant"}, grant, '0);
        chk({tag, "_done"}, req_done, '0);
        chk({tag, "_err"}, req_err, 1'b0);
        chk({tag, "_we"}, we, 1'b0);
        chk({tag, "_addr"}, si_address, '0);
        chk({tag, "_data"}, si_data, '0);
    endtask

    initial begin
        nreset = 1'b0;
        req_valid = '0; req_lock = '0; req_we = '0;
        req_address = '0; req_data = '0;
        set_phase('0, 0, 0, 1, 1);
        repeat (3) step();
        chk_zero("reset");
        nreset = 1'b1;
        repeat (2) step();

        // single write from requester 0, fin two cycles after exec
        set_phase('0, 0, 0, 1, 2);
        act[0] = 1'b1; left[0] = 1;
        req_valid[0] = 1'b1; req_lock[0] = 1'b0; req_we[0] = 1'b1;
        req_address[31:0] = 32'hA000_0010;
        req_data[31:0]    = 32'h1234_5678;
        wait_exec("single_exec");
        chk("single_grant", grant, 4'b0001);
        chk("single_we", we, 1'b1);
        chk("single_addr", si_address, 32'hA000_0010);
        chk("single_data", si_data, 32'h1234_5678);
        drain(100);
        chk("single_idle_grant", grant, '0);

        // contention: all valid, immediate fin -> rotating grants 4 cycles apart
        ex_cyc.delete(); ex_g.delete();
        set_phase(4'b1111, 4, 0, 1, 1);
        drain(500);
        chk("cont_count", 64'(ex_g.size()), 64'd16);
        for (int k = 1; k < ex_g.size() && k < 16; k++) begin
            chk("cont_order", ex_g[k], (ex_g[k-1] == 4'b1000) ? 4'b0001 : ex_g[k-1] << 1);
            chk("cont_spacing", 64'(ex_cyc[k] - ex_cyc[k-1]), 64'd4);
        end

        // locked burst on req1 while req2 waits
        ex_g.delete();
        set_phase('0, 0, 0, 1, 1);
        act[1] = 1'b1; left[1] = 4; new_beat(1);
        act[2] = 1'b1; left[2] = 1; new_beat(2);
        drain(200);
        chk("burst_count", 64'(ex_g.size()), 64'd5);
        for (int k = 0; k < 5 && k < ex_g.size(); k++)
            chk("burst_order", ex_g[k], (k < 4) ? 4'b0010 : 4'b0100);

        // timeouts: no fin at all, two requesters served in turn
        set_phase(4'b1001, 2, 0, 1, 3);
        drain(400);

        // randomised traffic: gaps, bursts, every fin scenario
        set_phase(4'b1111, 25, 6, 4, 0);
        drain(20000);

        // reset in the middle of WAIT while req2 holds a lock
        set_phase('0, 0, 0, 1, 3);
        act[2] = 1'b1; left[2] = 4; new_beat(2);
        wait_exec("rst_first_exec");
        repeat (3) step();
        nreset = 1'b0;
        act = '0;
        req_valid = '0; req_lock = '0;
        for (int i = 1; i < N; i++) begin
            act[i] = 1'b1;
            left[i] = 1;
            new_beat(i);
        end
        step();
        chk_zero("midwait_reset");
        nreset = 1'b1;
        wait_exec("post_reset_exec");
        chk("post_reset_grant", grant, 4'b0010);
        drain(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
